dcache_mem_responder: RTL and testbench

- Line-granular backing data memory that answers the data-cache controller's miss traffic: 256-bit line fills (reads) and dirty-line write-backs.
- Sits below the cache controller on the memory side of the 2-way data cache.
- Accepts one request at a time and completes it after a fixed, parameterised latency with a one-cycle ack pulse.

---
 rtl/dcache_mem_responder.sv | 93 +++++++++
 tb/tb_dcache_mem_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_mem_responder.sv
// rtl/dcache_mem_responder.sv - line-granular backing memory answering data-cache fills and write-backs
module dcache_mem_responder #(
    parameter int LATENCY    = 10,
    parameter int DEPTH_LOG2 = 9,
    parameter int LINE_W     = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [5:0] CNT_LAST = 6'(LATENCY - 2);

    state_t                  r_state;
    logic [5:0]              r_cnt;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic                    r_write;
    logic [LINE_W-1:0]       r_wdata;
    logic                    r_ack;
    logic                    r_busy;
    logic [LINE_W-1:0]       r_data;
    logic [LINE_W-1:0]       r_mem [0:(1<<DEPTH_LOG2)-1];

    logic [DEPTH_LOG2-1:0]   w_idx;
    logic                    w_unused_addr;

    // Byte offset and bits above the array size alias onto the same lines.
    assign w_idx         = addr_i[DEPTH_LOG2+4:5];
    assign w_unused_addr = ^{addr_i[31:DEPTH_LOG2+5], addr_i[4:0]};

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable_i) begin
                        r_idx   <= w_idx;
                        r_write <= write_i;
                        r_wdata <= data_i;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_ACK;
                        r_ack   <= 1'b1;
                        r_data  <= r_write ? '0 : r_mem[r_idx];
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_ACK: begin
                    r_ack   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_data  <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Write-back commits on the edge leaving ACK; a reset on that edge drops it.
    always_ff @(posedge clk_i) begin
        if (rst_i && (r_state == S_ACK) && r_write) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign ack_o  = r_ack;
    assign busy_o = r_busy;
    assign data_o = r_data;

endmodule

// File: tb/tb_dcache_mem_responder.sv
// tb/tb_dcache_mem_responder.sv - directed scoreboard bench for dcache_mem_responder
module tb_dcache_mem_responder;

    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         en, wr, ack, busy;
    logic [31:0]  addr;
    logic [255:0] din, dout;
    logic         en2, wr2, ack2, busy2;
    logic [31:0]  addr2;
    logic [255:0] din2, dout2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ack_count = 0;
    int ack_times[$];
    logic [255:0] exp_q[$];
    bit mon_on = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dcache_mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(9), .LINE_W(256)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .write_i(wr), .addr_i(addr),
        .data_i(din), .ack_o(ack), .data_o(dout), .busy_o(busy)
    );

    dcache_mem_responder #(.LATENCY(2), .DEPTH_LOG2(9), .LINE_W(256)) dut2 (
        .clk_i(clk), .rst_i(rst), .enable_i(en2), .write_i(wr2), .addr_i(addr2),
        .data_i(din2), .ack_o(ack2), .data_o(dout2), .busy_o(busy2)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every ack pops the scoreboard; outside ack, data_o must read zero.
    always @(negedge clk) begin
        if (mon_on) begin
            if (ack) begin
                ack_count++;
                ack_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 256'd1, 256'd0);
                end else begin
                    check("ack_data", dout, exp_q.pop_front());
                end
            end else begin
                check("idle_data_zero", dout, 256'd0);
            end
        end
    end

    task automatic req(input logic w, input logic [31:0] a, input logic [255:0] d,
                       input logic [255:0] exp, input bit disturb, input string tag);
        int acc, n0, i;
        @(negedge clk);
        en = 1'b1; wr = w; addr = a; din = d;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        acc = cyc; n0 = ack_count; en = 1'b0;
        check({tag, "_busy"}, 256'(busy), 256'd1);
        if (disturb) begin
            addr = 32'h0000_00E0; wr = 1'b1; din = '1;
        end
        i = 0;
        while (ack_count == n0 && i < 100) begin
            @(posedge clk);
            i++;
        end
        #1;
        check({tag, "_ack_seen"}, 256'(ack_count), 256'(n0 + 1));
        if (ack_count > n0)
            check({tag, "_latency"}, 256'(ack_times[n0] - acc), 256'(LAT - 1));
        addr = '0; wr = 1'b0; din = '0;
        check({tag, "_busy_after"}, 256'(busy), 256'd0);
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_single_ack"}, 256'(ack_count), 256'(n0 + 1));
    endtask

    initial begin
        int acc, n0, i;
        rst = 1'b0; en = 1'b0; wr = 1'b0; addr = '0; din = '0;
        en2 = 1'b0; wr2 = 1'b0; addr2 = '0; din2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 256'(ack), 256'd0);
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_data", dout, 256'd0);
        rst = 1'b1;
        mon_on = 1'b1;

        req(1'b1, 32'h0000_00E0, 256'h0777, 256'd0, 1'b0, "w7");
        req(1'b1, 32'h0000_0060, {32{8'hA5}}, 256'd0, 1'b0, "w3");
        req(1'b0, 32'h0000_0060, 256'd0, {32{8'hA5}}, 1'b0, "r3");

        // Inputs wiggled while busy must not change the in-flight read.
        req(1'b0, 32'h0000_0060, 256'd0, {32{8'hA5}}, 1'b1, "r3_dist");
        req(1'b0, 32'h0000_00E0, 256'd0, 256'h0777, 1'b0, "r7_kept");

        // Enable held high: write then read of the same line, 11 cycles apart.
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = 32'h0000_0100; din = 256'h1234;
        exp_q.push_back(256'd0);
        exp_q.push_back(256'h1234);
        n0 = ack_count;
        @(posedge clk); #1;
        acc = cyc; wr = 1'b0; din = '0;
        i = 0;
        while (ack_count < n0 + 2 && i < 100) begin
            @(posedge clk);
            i++;
        end
        #1;
        en = 1'b0;
        check("b2b_two_acks", 256'(ack_count), 256'(n0 + 2));
        if (ack_count >= n0 + 2) begin
            check("b2b_first_lat", 256'(ack_times[n0] - acc), 256'(LAT - 1));
            check("b2b_spacing", 256'(ack_times[n0+1] - ack_times[n0]), 256'(LAT + 1));
        end
        repeat (2) @(posedge clk);
        #1;
        check("b2b_idle", 256'(busy), 256'd0);

        // Reset in the 4th WAIT cycle drops the write.
        req(1'b1, 32'h0000_00A0, 256'h0BAD, 256'd0, 1'b0, "w5old");
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = 32'h0000_00A0; din = 256'hDEAD;
        @(posedge clk); #1;
        en = 1'b0; wr = 1'b0; n0 = ack_count;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check("midrst_busy", 256'(busy), 256'd0);
        check("midrst_ack", 256'(ack), 256'd0);
        check("midrst_data", dout, 256'd0);
        repeat (12) @(posedge clk);
        #1;
        check("midrst_no_ack", 256'(ack_count), 256'(n0));
        req(1'b0, 32'h0000_00A0, 256'd0, 256'h0BAD, 1'b0, "r5");

        // Upper address bits alias onto the same line.
        req(1'b1, 32'h0000_4020, 256'h77, 256'd0, 1'b0, "w_alias");
        req(1'b0, 32'h0000_0020, 256'd0, 256'h77, 1'b0, "r_alias");

        // LATENCY=2 instance: one WAIT cycle then ACK.
        @(negedge clk);
        en2 = 1'b1; wr2 = 1'b1; addr2 = 32'h0000_0040; din2 = 256'h5A;
        @(posedge clk); #1;
        en2 = 1'b0; wr2 = 1'b0;
        @(negedge clk);
        check("l2_w_wait", 256'(ack2), 256'd0);
        @(negedge clk);
        check("l2_w_ack", 256'(ack2), 256'd1);
        check("l2_w_data", dout2, 256'd0);
        @(negedge clk);
        check("l2_w_done", 256'(ack2), 256'd0);
        en2 = 1'b1; wr2 = 1'b0; addr2 = 32'h0000_0040;
        @(posedge clk); #1;
        en2 = 1'b0;
        check("l2_r_busy", 256'(busy2), 256'd1);
        @(negedge clk);
        check("l2_r_wait", 256'(ack2), 256'd0);
        @(negedge clk);
        check("l2_r_ack", 256'(ack2), 256'd1);
        check("l2_r_data", dout2, 256'h5A);
        @(negedge clk);
        check("l2_r_done", 256'(ack2), 256'd0);
        check("l2_r_idle", 256'(busy2), 256'd0);
        check("l2_r_zero", dout2, 256'd0);

        check("scoreboard_empty", 256'(exp_q.size()), 256'd0);
        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
